// File: rtl/mc_core_pkg.sv
// Shared definitions for the multicycle core: FSM states, instruction field
// positions, ALU/compare opcodes, write-select codes and the decoded form.
package mc_core_pkg;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_EXEC  = 2'd1,
        S_HALT  = 2'd2
    } state_t;

    // instruction field bit positions
    localparam int J_BIT  = 31;
    localparam int B_BIT  = 30;
    localparam int WS_HI  = 29;
    localparam int WS_LO  = 28;
    localparam int OP_HI  = 27;
    localparam int OP_LO  = 23;
    localparam int RA1_HI = 22;
    localparam int RA1_LO = 18;
    localparam int RA2_HI = 17;
    localparam int RA2_LO = 13;
    localparam int C_HI   = 12;
    localparam int C_LO   = 5;
    localparam int WA_HI  = 4;
    localparam int WA_LO  = 0;

    // write-select codes
    localparam logic [1:0] WS_NONE  = 2'b00;
    localparam logic [1:0] WS_HALT  = 2'b01;
    localparam logic [1:0] WS_ALU   = 2'b10;
    localparam logic [1:0] WS_CONST = 2'b11;

    // arithmetic / logic ops
    localparam logic [4:0] OP_ADD  = 5'b00000;
    localparam logic [4:0] OP_SUB  = 5'b01000;
    localparam logic [4:0] OP_XOR  = 5'b00100;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_AND  = 5'b00111;
    localparam logic [4:0] OP_SLL  = 5'b00001;
    localparam logic [4:0] OP_SRL  = 5'b00101;
    localparam logic [4:0] OP_SRA  = 5'b01101;
    localparam logic [4:0] OP_SLT  = 5'b00010;
    localparam logic [4:0] OP_SLTU = 5'b00011;

    // compare ops: drive the branch flag, result is zero
    localparam logic [4:0] OP_BEQ  = 5'b11000;
    localparam logic [4:0] OP_BNE  = 5'b11001;
    localparam logic [4:0] OP_BLT  = 5'b11100;
    localparam logic [4:0] OP_BGE  = 5'b11101;
    localparam logic [4:0] OP_BLTU = 5'b11110;
    localparam logic [4:0] OP_BGEU = 5'b11111;

    typedef struct packed {
        logic       j;
        logic       b;
        logic [1:0] ws;
        logic [4:0] op;
        logic [4:0] ra1;
        logic [4:0] ra2;
        logic [7:0] cnst;
        logic [4:0] wa;
    } instr_t;

    function automatic instr_t decode(input logic [31:0] w);
        instr_t d;
        d.j    = w[J_BIT];
        d.b    = w[B_BIT];
        d.ws   = w[WS_HI:WS_LO];
        d.op   = w[OP_HI:OP_LO];
        d.ra1  = w[RA1_HI:RA1_LO];
        d.ra2  = w[RA2_HI:RA2_LO];
        d.cnst = w[C_HI:C_LO];
        d.wa   = w[WA_HI:WA_LO];
        return d;
    endfunction

endpackage

// File: rtl/mc_regfile.sv
// Register file: two operand reads, one debug read, one write port.
// x0 and addresses at or above NREG read as zero and ignore writes.
module mc_regfile
    import mc_core_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int NREG = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [4:0]      ra1,
    input  logic [4:0]      ra2,
    output logic [XLEN-1:0] rd1,
    output logic [XLEN-1:0] rd2,
    input  logic            we,
    input  logic [4:0]      wa,
    input  logic [XLEN-1:0] wd,
    input  logic [4:0]      dbg_ra,
    output logic [XLEN-1:0] dbg_rd
);
    localparam int AW = $clog2(NREG);

    logic [XLEN-1:0] regs [NREG];

    // write port; entry 0 is held at zero and never written
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else if (we) begin
            for (int i = 1; i < NREG; i++)
                if (int'(wa) == i) regs[i] <= wd;
        end
    end

    // read ports are combinational, so a same-cycle write is seen only next cycle
    assign rd1    = (ra1 == 5'd0 || int'(ra1) >= NREG) ? '0 : regs[ra1[AW-1:0]];
    assign rd2    = (ra2 == 5'd0 || int'(ra2) >= NREG) ? '0 : regs[ra2[AW-1:0]];
    assign dbg_rd = (dbg_ra == 5'd0 || int'(dbg_ra) >= NREG) ? '0 : regs[dbg_ra[AW-1:0]];

endmodule

// File: rtl/multicycle_core.sv
// Two-cycle-per-instruction core: FETCH waits for the instruction memory
// handshake, EXEC reads operands, evaluates the ALU and commits in one cycle.
module multicycle_core
    import mc_core_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int PC_W = 8,
    parameter int NREG = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            run,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [31:0]     imem_rdata,
    output logic            retire,
    output logic            halted,
    output logic [PC_W-1:0] pc,
    input  logic [4:0]      dbg_ra,
    output logic [XLEN-1:0] dbg_rd
);
    localparam int SHW = $clog2(XLEN);

    state_t          state;
    logic [PC_W-1:0] pc_q;
    logic [31:0]     ir;
    instr_t          d;

    logic [XLEN-1:0] rd1, rd2, res, wd;
    logic            flag, we, take, is_halt;
    logic [SHW-1:0]  sh;
    logic signed [7:0] cs;
    logic [PC_W-1:0] pc_next;

    assign d       = decode(ir);
    assign sh      = rd2[SHW-1:0];
    assign cs      = signed'(d.cnst);
    assign is_halt = (d.ws == WS_HALT) && !d.j && !d.b;

    mc_regfile #(.XLEN(XLEN), .NREG(NREG)) u_rf (
        .clk    (clk),
        .rst    (rst),
        .ra1    (d.ra1),
        .ra2    (d.ra2),
        .rd1    (rd1),
        .rd2    (rd2),
        .we     (we),
        .wa     (d.wa),
        .wd     (wd),
        .dbg_ra (dbg_ra),
        .dbg_rd (dbg_rd)
    );

    // ALU and compare unit; compares only raise the flag
    always_comb begin
        res  = '0;
        flag = 1'b0;
        case (d.op)
            OP_ADD:  res = rd1 + rd2;
            OP_SUB:  res = rd1 - rd2;
            OP_XOR:  res = rd1 ^ rd2;
            OP_OR:   res = rd1 | rd2;
            OP_AND:  res = rd1 & rd2;
            OP_SLL:  res = rd1 << sh;
            OP_SRL:  res = rd1 >> sh;
            OP_SRA:  res = $signed(rd1) >>> sh;
            OP_SLT:  res[0] = $signed(rd1) < $signed(rd2);
            OP_SLTU: res[0] = rd1 < rd2;
            OP_BEQ:  flag = rd1 == rd2;
            OP_BNE:  flag = rd1 != rd2;
            OP_BLT:  flag = $signed(rd1) < $signed(rd2);
            OP_BGE:  flag = $signed(rd1) >= $signed(rd2);
            OP_BLTU: flag = rd1 < rd2;
            OP_BGEU: flag = rd1 >= rd2;
            default: ;
        endcase
    end

    // write-back select and next-PC; PC arithmetic wraps at 2^PC_W
    always_comb begin
        we      = (state == S_EXEC) && (d.ws == WS_ALU || d.ws == WS_CONST);
        wd      = (d.ws == WS_CONST) ? XLEN'(cs) : res;
        take    = d.j || (d.b && flag);
        pc_next = take ? pc_q + PC_W'(cs) : pc_q + PC_W'(1);
    end

    // request is live only in FETCH with run high, and never while in reset
    assign imem_req  = (state == S_FETCH) && run && !rst;
    assign imem_addr = pc_q;
    assign pc        = pc_q;

    // control FSM with registered retire/halted flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_FETCH;
            pc_q   <= '0;
            ir     <= '0;
            retire <= 1'b0;
            halted <= 1'b0;
        end else begin
            case (state)
                S_FETCH: begin
                    if (imem_req && imem_ack) begin
                        ir     <= imem_rdata;
                        state  <= S_EXEC;
                        retire <= 1'b1;
                    end
                end
                S_EXEC: begin
                    retire <= 1'b0;
                    if (is_halt) begin
                        state  <= S_HALT;
                        halted <= 1'b1;
                    end else begin
                        state  <= S_FETCH;
                        pc_q   <= pc_next;
                    end
                end
                S_HALT: begin
                    retire <= 1'b0;
                    halted <= 1'b1;
                end
                default: begin
                    state  <= S_FETCH;
                    retire <= 1'b0;
                    halted <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_core.sv
// Bench for multicycle_core: an instruction-level model predicts each retired
// instruction; a monitor compares PC, halt status and the destination register.
module tb_multicycle_core;
    localparam int XLEN = 32;
    localparam int PC_W = 8;
    localparam int NREG = 32;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            run = 1'b0;
    logic            imem_ack = 1'b0;
    logic [31:0]     imem_rdata = '0;
    logic            imem_req, retire, halted;
    logic [PC_W-1:0] imem_addr, pc;
    logic [4:0]      dbg_ra;
    logic [XLEN-1:0] dbg_rd;

    logic [4:0] drv_ra = '0, mon_ra = '0;
    logic       drv_own = 1'b0;
    assign dbg_ra = drv_own ? drv_ra : mon_ra;

    always #5 clk = ~clk;

    multicycle_core #(.XLEN(XLEN), .PC_W(PC_W), .NREG(NREG)) dut (
        .clk(clk), .rst(rst), .run(run),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .retire(retire), .halted(halted), .pc(pc),
        .dbg_ra(dbg_ra), .dbg_rd(dbg_rd)
    );

    int n_chk = 0, n_pass = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [PC_W-1:0] pc;
        logic            halt;
        logic [4:0]      wa;
        logic [XLEN-1:0] val;
    } exp_t;

    exp_t            sbq[$];
    logic [XLEN-1:0] m_x [32];
    logic [PC_W-1:0] m_pc;

    function automatic void model_reset();
        foreach (m_x[i]) m_x[i] = '0;
        m_pc = '0;
    endfunction

    function automatic logic [XLEN-1:0] mreg(input logic [4:0] r);
        if (r == 0 || int'(r) >= NREG) return '0;
        return m_x[r];
    endfunction

    function automatic exp_t model_exec(input logic [31:0] w);
        exp_t e;
        logic j = w[31], b = w[30];
        logic [1:0] ws = w[29:28];
        logic [4:0] op = w[27:23];
        logic [XLEN-1:0] a = mreg(w[22:18]);
        logic [XLEN-1:0] bv = mreg(w[17:13]);
        logic [7:0] c8 = w[12:5];
        logic [4:0] wa = w[4:0];
        int ci = int'($signed(c8));
        logic [4:0] sh = bv[4:0];
        logic [XLEN-1:0] r = '0;
        logic f = 1'b0;
        logic halt = (ws == 2'b01) && !j && !b;
        case (op)
            5'b00000: r = a + bv;
            5'b01000: r = a - bv;
            5'b00100: r = a ^ bv;
            5'b00110: r = a | bv;
            5'b00111: r = a & bv;
            5'b00001: r = a << sh;
            5'b00101: r = a >> sh;
            5'b01101: r = $signed(a) >>> sh;
            5'b00010: r = ($signed(a) < $signed(bv)) ? 1 : 0;
            5'b00011: r = (a < bv) ? 1 : 0;
            5'b11000: f = (a == bv);
            5'b11001: f = (a != bv);
            5'b11100: f = ($signed(a) < $signed(bv));
            5'b11101: f = ($signed(a) >= $signed(bv));
            5'b11110: f = (a < bv);
            5'b11111: f = (a >= bv);
            default: ;
        endcase
        if (wa != 0 && int'(wa) < NREG) begin
            if (ws == 2'b10) m_x[wa] = r;
            else if (ws == 2'b11) m_x[wa] = XLEN'(ci);
        end
        if (!halt) begin
            if (j || (b && f)) m_pc = PC_W'(int'(m_pc) + ci);
            else               m_pc = PC_W'(int'(m_pc) + 1);
        end
        e.pc = m_pc; e.halt = halt; e.wa = wa; e.val = mreg(wa);
        return e;
    endfunction

    function automatic logic [31:0] mk(input bit j, input bit b, input logic [1:0] ws,
                                       input logic [4:0] op, input logic [4:0] r1,
                                       input logic [4:0] r2, input logic [7:0] c,
                                       input logic [4:0] wa);
        return {j, b, ws, op, r1, r2, c, wa};
    endfunction

    logic [4:0] ops [16] = '{5'b00000, 5'b01000, 5'b00100, 5'b00110, 5'b00111,
                             5'b00001, 5'b00101, 5'b01101, 5'b00010, 5'b00011,
                             5'b11000, 5'b11001, 5'b11100, 5'b11101, 5'b11110, 5'b11111};

    function automatic logic [31:0] rand_instr();
        bit j = ($urandom_range(0, 11) == 0);
        bit b = ($urandom_range(0, 3) == 0);
        logic [1:0] ws;
        logic [4:0] op;
        case ($urandom_range(0, 2))
            0: ws = 2'b00;
            1: ws = 2'b10;
            default: ws = 2'b11;
        endcase
        if ((j || b) && $urandom_range(0, 7) == 0) ws = 2'b01;
        op = ($urandom_range(0, 9) == 0) ? 5'($urandom) : ops[$urandom_range(0, 15)];
        return mk(j, b, ws, op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                  8'($urandom), 5'($urandom_range(0, 7)));
    endfunction

    // ---------------- monitor / scoreboard ----------------
    exp_t mon_e;
    initial begin
        forever begin
            @(negedge clk);
            if (retire === 1'b1) begin
                if (sbq.size() == 0) begin
                    check("spurious_retire", retire, 0);
                end else begin
                    mon_e = sbq.pop_front();
                    @(posedge clk); #1;
                    check("pc", pc, mon_e.pc);
                    check("halted", halted, mon_e.halt);
                    mon_ra = mon_e.wa; #1;
                    check($sformatf("x%0d", mon_e.wa), dbg_rd, mon_e.val);
                end
            end
        end
    end

    // ---------------- driver helpers ----------------
    task automatic feed(input logic [31:0] w, input int dly);
        int k = 0;
        while (!imem_req && k < 50) begin @(posedge clk); #1; k++; end
        if (!imem_req) begin check("req_timeout", imem_req, 1); return; end
        repeat (dly) begin
            @(posedge clk); #1;
            check("req_stable", {imem_req, imem_addr}, {1'b1, m_pc});
        end
        check("imem_addr", imem_addr, m_pc);
        sbq.push_back(model_exec(w));
        imem_rdata = w; imem_ack = 1'b1;
        @(posedge clk); #1;
        imem_ack = 1'b0; imem_rdata = $urandom;
        check("exec_retire", retire, 1);
        check("exec_noreq", imem_req, 0);
        @(posedge clk); #3;
        check("post_exec_retire", retire, 0);
    endtask

    task automatic rd_reg(input logic [4:0] r, output logic [XLEN-1:0] v);
        drv_own = 1'b1; drv_ra = r; #1;
        v = dbg_rd; drv_own = 1'b0;
    endtask

    logic [XLEN-1:0] v;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        model_reset();
        repeat (3) @(posedge clk); #1;
        check("rst_req", imem_req, 0);
        check("rst_retire", retire, 0);
        check("rst_halted", halted, 0);
        check("rst_pc", pc, 0);
        rd_reg(5'd3, v); check("rst_x3", v, 0);
        run = 1'b1; #1;
        check("req_in_rst", imem_req, 0);
        rst = 1'b0; #1;
        check("first_req", {imem_req, imem_addr}, {1'b1, 8'h00});

        // load constant, ack same cycle
        feed(mk(0, 0, 2'b11, 5'd0, 5'd0, 5'd0, 8'hFE, 5'd3), 0);
        check("c_pc1", pc, 8'h01);
        rd_reg(5'd3, v); check("c_x3", v, 32'hFFFFFFFE);

        // BEQ taken / not taken from pc 10
        feed(mk(0, 0, 2'b11, 5'd0, 5'd0, 5'd0, 8'd5, 5'd1), 1);
        feed(mk(0, 0, 2'b11, 5'd0, 5'd0, 5'd0, 8'd5, 5'd2), 2);
        feed(mk(1, 0, 2'b00, 5'd0, 5'd0, 5'd0, 8'd7, 5'd0), 0);
        check("c_pc10", pc, 8'd10);
        feed(mk(0, 1, 2'b00, 5'b11000, 5'd1, 5'd2, 8'h04, 5'd0), 0);
        check("c_beq_taken", pc, 8'd14);
        feed(mk(0, 0, 2'b11, 5'd0, 5'd0, 5'd0, 8'd6, 5'd2), 0);
        feed(mk(1, 0, 2'b00, 5'd0, 5'd0, 5'd0, 8'hFB, 5'd0), 0);
        feed(mk(0, 1, 2'b00, 5'b11000, 5'd1, 5'd2, 8'h04, 5'd0), 0);
        check("c_beq_not", pc, 8'd11);

        // jump wrap-around
        feed(mk(1, 0, 2'b00, 5'd0, 5'd0, 5'd0, 8'hE5, 5'd0), 0);
        check("c_pcF0", pc, 8'hF0);
        feed(mk(1, 0, 2'b00, 5'd0, 5'd0, 5'd0, 8'h7F, 5'd0), 0);
        check("c_wrap", pc, 8'h6F);

        // x0 write ignored; SUB giving negative result
        feed(mk(0, 0, 2'b10, 5'b00000, 5'd1, 5'd2, 8'd0, 5'd0), 0);
        rd_reg(5'd0, v); check("c_x0", v, 0);
        feed(mk(0, 0, 2'b11, 5'd0, 5'd0, 5'd0, 8'd3, 5'd3), 0);
        feed(mk(0, 0, 2'b11, 5'd0, 5'd0, 5'd0, 8'd5, 5'd4), 0);
        feed(mk(0, 0, 2'b10, 5'b01000, 5'd3, 5'd4, 8'd0, 5'd5), 1);
        rd_reg(5'd5, v); check("c_sub", v, 32'hFFFFFFFE);
        // same-instruction read and write of x3 reads old value
        feed(mk(0, 0, 2'b10, 5'b00000, 5'd3, 5'd3, 8'd0, 5'd3), 0);
        rd_reg(5'd3, v); check("c_rw_old", v, 32'd6);

        // run drop with request pending: no latch, ack without request ignored
        @(posedge clk); #1;
        run = 1'b0; #1;
        check("run_drop_req", imem_req, 0);
        imem_ack = 1'b1; imem_rdata = mk(0, 0, 2'b11, 5'd0, 5'd0, 5'd0, 8'h55, 5'd6);
        @(posedge clk); #1;
        imem_ack = 1'b0;
        check("run_drop_noretire", retire, 0);
        check("run_drop_pc", pc, m_pc);
        run = 1'b1;

        // randomized traffic
        for (int i = 0; i < 150; i++) feed(rand_instr(), $urandom_range(0, 3));

        // reset during EXEC abandons the instruction
        imem_rdata = mk(0, 0, 2'b11, 5'd0, 5'd0, 5'd0, 8'h33, 5'd7);
        imem_ack = 1'b1;
        @(posedge clk); #1;
        imem_ack = 1'b0;
        check("mid_exec_retire", retire, 1);
        rst = 1'b1; #1;
        check("rst_exec_retire", retire, 0);
        check("rst_exec_pc", pc, 0);
        model_reset();
        @(posedge clk); #1;
        rst = 1'b0; #2;
        rd_reg(5'd7, v); check("rst_exec_x7", v, 0);

        // halt is sticky and silent
        feed(mk(0, 0, 2'b11, 5'd0, 5'd0, 5'd0, 8'h21, 5'd2), 0);
        feed(mk(0, 0, 2'b01, 5'd0, 5'd2, 5'd2, 8'h10, 5'd2), 0);
        check("halt_set", halted, 1);
        imem_ack = 1'b1;
        begin
            int bad = 0;
            repeat (20) begin
                @(posedge clk); #1;
                if (imem_req !== 1'b0 || retire !== 1'b0 || halted !== 1'b1) bad++;
            end
            check("halt_quiet20", bad, 0);
        end
        imem_ack = 1'b0;
        check("halt_pc", pc, m_pc);
        rd_reg(5'd2, v); check("halt_x2", v, 32'h21);
        rst = 1'b1; #1;
        check("halt_cleared", halted, 0);
        model_reset();
        @(posedge clk); #1;
        rst = 1'b0;

        // delayed ack with reset during the wait
        repeat (2) begin @(posedge clk); #1; end
        check("wait_req", imem_req, 1);
        rst = 1'b1; #1;
        check("wait_rst_req", imem_req, 0);
        imem_ack = 1'b1; imem_rdata = mk(0, 0, 2'b11, 5'd0, 5'd0, 5'd0, 8'h44, 5'd1);
        @(posedge clk); #1;
        imem_ack = 1'b0;
        check("wait_rst_retire", retire, 0);
        check("wait_rst_pc", pc, 0);
        rst = 1'b0; #1;
        feed(mk(0, 0, 2'b11, 5'd0, 5'd0, 5'd0, 8'h12, 5'd1), 0);
        check("after_rst_pc", pc, 8'd1);

        repeat (4) @(posedge clk);
        check("sb_drained", sbq.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
